// File: rtl/debounce_bank_if.sv
// debounce_bank_if: button bus between the raw push-buttons and the debouncer.
//   pb      : raw, asynchronous button levels (driven by the board side)
//   pb_out  : debounced levels
//   pb_rise : one-cycle pulse per channel on a debounced 0->1
//   pb_fall : one-cycle pulse per channel on a debounced 1->0
//   tick    : one-cycle shared sample strobe
// master = board/consumer side, slave = debouncer.
interface debounce_bank_if #(
  parameter int unsigned N = 4
) ();
  logic [N-1:0] pb;
  logic [N-1:0] pb_out;
  logic [N-1:0] pb_rise;
  logic [N-1:0] pb_fall;
  logic         tick;

  modport master (
    output pb,
    input  pb_out,
    input  pb_rise,
    input  pb_fall,
    input  tick
  );

  modport slave (
    input  pb,
    output pb_out,
    output pb_rise,
    output pb_fall,
    output tick
  );
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank: N-channel push-button debouncer.
//   Each raw input is synchronised by two flops, sampled on a shared
//   prescaled tick, and the debounced level changes only after
//   STABLE_SAMPLES consecutive samples disagree with it.
// Ports:
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : debounce_bank_if.slave (pb in; pb_out, pb_rise, pb_fall, tick out)
// Optional feature: define DEBOUNCE_EDGE_EN to build the registered
//   pb_rise/pb_fall pulse logic; otherwise both are tied to 0.
module debounce_bank #(
  parameter int unsigned N              = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  debounce_bank_if.slave  bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SAMPLES - 1);

  logic [N-1:0]     r_s1;
  logic [N-1:0]     r_s2;
  logic [N-1:0]     r_pb_out;
  logic [N-1:0]     w_pb_out_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic [CNT_W-1:0] r_cnt     [N];
  logic [CNT_W-1:0] w_cnt_nxt [N];

  // Prescaler: the registered tick is high exactly while r_div == CLK_DIV-1.
  always_comb begin
    w_div_nxt  = (r_div == DIV_MAX) ? '0 : r_div + DIV_W'(1);
    w_tick_nxt = (w_div_nxt == DIV_MAX);
  end

  // Per-channel stability counters; any matching sample clears the run.
  always_comb begin
    w_pb_out_nxt = r_pb_out;
    w_cnt_nxt    = r_cnt;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_tick) begin
        if (r_s2[i] == r_pb_out[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          w_pb_out_nxt[i] = r_s2[i];
          w_cnt_nxt[i]    = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser, prescaler and debounced state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_div    <= '0;
      r_tick   <= 1'b0;
      r_pb_out <= '0;
      r_cnt    <= '{default: '0};
    end else begin
      r_s1     <= bus.pb;
      r_s2     <= r_s1;
      r_div    <= w_div_nxt;
      r_tick   <= w_tick_nxt;
      r_pb_out <= w_pb_out_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.pb_out = r_pb_out;
  assign bus.tick   = r_tick;

`ifdef DEBOUNCE_EDGE_EN
  logic [N-1:0] r_rise;
  logic [N-1:0] r_fall;

  // Pulses are registered alongside pb_out so they coincide with its change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_pb_out_nxt & ~r_pb_out;
      r_fall <= ~w_pb_out_nxt & r_pb_out;
    end
  end

  assign bus.pb_rise = r_rise;
  assign bus.pb_fall = r_fall;
`else
  assign bus.pb_rise = '0;
  assign bus.pb_fall = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: scoreboard bench for debounce_bank.
//   DUT a: N=2, CLK_DIV=4, STABLE_SAMPLES=3.
//   DUT b: N=2, CLK_DIV=1, STABLE_SAMPLES=1.
// Stimulus pushes the expected next pb_out value and its cycle window;
// the monitor pops an entry whenever a DUT's pb_out changes.
module tb_debounce_bank;
  localparam int unsigned N = 2;

  typedef struct packed {
    logic [1:0] val;
    int         lo;
    int         hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debounce_bank_if #(.N(N)) bus_a ();
  debounce_bank_if #(.N(N)) bus_b ();

  debounce_bank #(.N(N), .CLK_DIV(4), .STABLE_SAMPLES(3)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  debounce_bank #(.N(N), .CLK_DIV(1), .STABLE_SAMPLES(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  exp_t       q [2][$];
  logic [1:0] prev [2] = '{default: 2'b00};
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc = 0;
  int         since_rst = 0;
  logic       rst_at_edge = 1'b1;

  // Cycle bookkeeping: cyc counts rising edges, since_rst counts edges since the last reset edge.
  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst;
    if (rst) since_rst = 0;
    else     since_rst++;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  task automatic mon(input int id, input logic [1:0] out, input logic [1:0] rise,
                     input logic [1:0] fall, input logic tick, input logic exp_tick);
    exp_t       e;
    logic [1:0] er;
    logic [1:0] ef;
    string      tag;
    tag = (id == 0) ? "a" : "b";
    if (rst_at_edge) begin
      chk({tag, "_rst_out"},  32'(out),  32'd0);
      chk({tag, "_rst_rise"}, 32'(rise), 32'd0);
      chk({tag, "_rst_fall"}, 32'(fall), 32'd0);
      chk({tag, "_rst_tick"}, 32'(tick), 32'd0);
      prev[id] = 2'b00;
    end else begin
      chk({tag, "_tick"}, 32'(tick), 32'(exp_tick));
      er = 2'b00;
      ef = 2'b00;
      if (out !== prev[id]) begin
        if (q[id].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s_unexpected_change: got %0h expected %0h at cycle %0d", tag, out, prev[id], cyc);
        end else begin
          e = q[id].pop_front();
          chk({tag, "_out_val"}, 32'(out), 32'(e.val));
          n_tests++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_fail++;
            $display("FAIL %s_latency: changed at cycle %0d expected %0d..%0d", tag, cyc, e.lo, e.hi);
          end
        end
`ifdef DEBOUNCE_EDGE_EN
        er = out & ~prev[id];
        ef = ~out & prev[id];
`endif
      end
      chk({tag, "_rise"}, 32'(rise), 32'(er));
      chk({tag, "_fall"}, 32'(fall), 32'(ef));
      prev[id] = out;
    end
  endtask

  // Monitor: sample both DUTs on the falling edge.
  always @(negedge clk) begin
    mon(0, bus_a.pb_out, bus_a.pb_rise, bus_a.pb_fall, bus_a.tick, (since_rst % 4) == 3);
    mon(1, bus_b.pb_out, bus_b.pb_rise, bus_b.pb_fall, bus_b.tick, since_rst >= 1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive DUT a; a clean step reaches pb_out 11..14 edges after the drive.
  task automatic drive_a(input logic [1:0] v, input logic expect_change);
    exp_t e;
    bus_a.pb = v;
    if (expect_change) begin
      e.val = v;
      e.lo  = cyc + 11;
      e.hi  = cyc + 14;
      q[0].push_back(e);
    end
  endtask

  // Drive DUT b; with CLK_DIV=1, STABLE_SAMPLES=1 the latency is exactly 3 edges.
  task automatic drive_b(input logic [1:0] v);
    exp_t e;
    if (v !== bus_b.pb) begin
      e.val = v;
      e.lo  = cyc + 3;
      e.hi  = cyc + 3;
      q[1].push_back(e);
    end
    bus_b.pb = v;
  endtask

  logic [1:0] b_vals [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00};
  int         b_gaps [8] = '{1, 1, 2, 1, 3, 1, 1, 5};

  initial begin
    exp_t e;
    bus_a.pb = 2'b11;
    bus_b.pb = 2'b00;
    rst      = 1'b1;
    step(3);

    // Inputs held high through reset re-qualify from zero.
    rst = 1'b0;
    e.val = 2'b11; e.lo = cyc + 11; e.hi = cyc + 14;
    q[0].push_back(e);
    step(20);
    drive_a(2'b00, 1'b1);
    step(20);

    // Clean press/release on channel 0.
    drive_a(2'b01, 1'b1);
    step(40);
    drive_a(2'b00, 1'b1);
    step(20);

    // Short glitch must be rejected.
    drive_a(2'b01, 1'b0);
    step(6);
    drive_a(2'b00, 1'b0);
    step(30);

    // Bounce train, phased so the single low cycle lands on a sample.
    for (int i = 0; i < 8 && (since_rst % 4) != 3; i++) step(1);
    drive_a(2'b01, 1'b0); step(3);
    drive_a(2'b00, 1'b0); step(2);
    drive_a(2'b01, 1'b0); step(5);
    drive_a(2'b00, 1'b0); step(1);
    drive_a(2'b01, 1'b1); step(20);
    drive_a(2'b00, 1'b1); step(20);

    // Simultaneous channels.
    drive_a(2'b11, 1'b1); step(20);
    drive_a(2'b00, 1'b1); step(20);

    // Reset after two matching samples discards the partial count.
    drive_a(2'b11, 1'b0);
    step(10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    e.val = 2'b11; e.lo = cyc + 11; e.hi = cyc + 14;
    q[0].push_back(e);
    step(20);
    drive_a(2'b00, 1'b1);
    step(20);

    // Corner instance: follows pb with fixed latency, including back-to-back changes.
    for (int i = 0; i < 8; i++) begin
      drive_b(b_vals[i]);
      step(b_gaps[i]);
    end

    // Drain outstanding expectations with a bounded wait.
    for (int i = 0; i < 40 && (q[0].size() != 0 || q[1].size() != 0); i++) step(1);
    chk("a_pending", 32'(q[0].size()), 32'd0);
    chk("b_pending", 32'(q[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button debouncer: N asynchronous button inputs are synchronised to `clk`, sampled on a shared prescaled tick, and each channel's output changes only after the input holds a new level for a configurable number of consecutive samples. It replaces the single-channel fixed three-flop debouncer. It sits between the board push-buttons and any FSM or counter logic that consumes clean levels or single-cycle press and release pulses.

## Interface
- `N`, 4: number of independent channels; legal ≥ 1.
- `CLK_DIV`, 50000: `clk` cycles per sample tick; legal ≥ 1 (1 = sample every cycle).
- `STABLE_SAMPLES`, 3: consecutive differing samples needed to change an output; legal ≥ 1.
- `clk`  input  1  single system clock; all state on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `pb`  input  N  raw button levels; asynchronous, may bounce.
- `pb_out`  output  N  debounced levels.
- `pb_rise`  output  N  one-cycle pulse per channel on debounced 0→1.
- `pb_fall`  output  N  one-cycle pulse per channel on debounced 1→0.
- `tick`  output  1  one-cycle sample strobe; exported for sharing.

## Operation
- Synchroniser: two flops per channel on `clk`: `pb` → `s1` → `s2`. Only `s2` is used downstream.
- Prescaler: counter `0..CLK_DIV-1`, width `$clog2(CLK_DIV)` (min 1). `tick` = 1 in the cycle the count equals `CLK_DIV-1`; the count then wraps to 0. When `CLK_DIV=1`, `tick` is constantly 1 outside reset.
- Per-channel stability counter, width `$clog2(STABLE_SAMPLES+1)`. Update only in cycles where `tick` = 1:
  - `s2 == pb_out`: counter ← 0.
  - `s2 != pb_out` and counter == `STABLE_SAMPLES-1`: `pb_out` ← `s2`, counter ← 0.
  - `s2 != pb_out` otherwise: counter ← counter + 1.
- A single matching sample clears the count, so only an unbroken run of `STABLE_SAMPLES` differing samples changes the output. The counter never exceeds `STABLE_SAMPLES-1`.
- Channels are fully independent. Simultaneous transitions on several channels are each handled on the same tick.
- Edge pulses: `pb_rise[i]` and `pb_fall[i]` are registered and assert in the same cycle `pb_out[i]` takes its new value, for exactly one `clk`.
  - At most one of the two is high per channel per cycle.
  - They cannot assert in consecutive cycles unless `CLK_DIV=1` and `STABLE_SAMPLES=1`.

## Timing
- Reset values, applied at the first rising edge with `rst` = 1: synchroniser flops, prescaler, stability counters, `pb_out`, `pb_rise`, `pb_fall`, and `tick` are all 0.
- Reset asserted mid-qualification discards partial counts.
- An input already held high through reset re-qualifies from zero after `rst` falls.
- Input-to-output latency for a clean step: 2 cycles of synchronisation, plus the wait to the next tick (1..`CLK_DIV` cycles), plus `(STABLE_SAMPLES-1)·CLK_DIV` cycles.
  - Example: `CLK_DIV=4`, `STABLE_SAMPLES=3` gives 11..14 cycles.
- Pulses shorter than `(STABLE_SAMPLES-1)·CLK_DIV` cycles (measured after `s2`) are guaranteed rejected.
- Outputs are registered; no combinational path runs from `pb` to any output.

## Configuration
- `DEBOUNCE_EDGE_EN` defined: the `pb_rise`/`pb_fall` registers and logic are built as described above.
- `DEBOUNCE_EDGE_EN` undefined:
  - `pb_rise` and `pb_fall` remain ports and are tied to constant 0.
  - No edge registers are synthesised.
  - `pb_out` behaviour is unchanged.

## Test plan
Bench uses `N=2`, `CLK_DIV=4`, `STABLE_SAMPLES=3` unless stated.
- Reset: hold `rst` for 3 cycles with `pb=2'b11` → all outputs 0 during reset. `pb_out=2'b11` appears 11..14 cycles after `rst` falls, with `pb_rise=2'b11` for one cycle in the same cycle.
- Clean press/release on ch0: `pb[0]` 0→1, held 40 cycles, then 1→0 → `pb_out[0]` rises 11..14 cycles after the press with a one-cycle `pb_rise[0]`. It falls 11..14 cycles after the release with a one-cycle `pb_fall[0]`. `pb_out[1]` stays 0 throughout.
- Glitch rejection: `pb[0]` high for 6 cycles, then low → `pb_out[0]`, `pb_rise[0]`, and `pb_fall[0]` stay 0. Repeat with a bounce train: 3 high, 2 low, 5 high, 1 low, then held high → `pb_out[0]` rises only after the final held level has been sampled 3 consecutive ticks.
- Simultaneous channels plus reset mid-count: both `pb` bits rise together → both `pb_out` bits and both `pb_rise` bits assert in the same cycle. Assert `rst` for 1 cycle after 2 matching ticks of a new press → no output change, and the full 3-tick count restarts after reset.
- Corner parameters: `CLK_DIV=1`, `STABLE_SAMPLES=1` → `tick` is constantly 1 after reset, and `pb_out` follows `pb` with exactly 3 cycles of latency. Without `DEBOUNCE_EDGE_EN` → `pb_rise` and `pb_fall` are 0 in every scenario.
